// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared datapath width, opcode map and exec-unit state encoding
package cpu_alu_pkg;
    localparam int WIDTH   = 24;
    localparam int SHAMT_W = 5;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b1010;
    typedef enum logic {IDLE, MUL} exec_state_t;
endpackage

// File: rtl/seq_multiplier24.sv
// seq_multiplier24: unsigned shift-add multiplier, one multiplier bit per step
module seq_multiplier24
    import cpu_alu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           step,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    assign product = mplier[0] ? acc + mcand : acc;
    assign done    = step && cnt == LAST;
    // load operands, then accumulate one partial product per step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{W{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= done ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle logic/arith ops plus 24-cycle MUL with start/busy/done
module alu_exec_unit
    import cpu_alu_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    exec_state_t        state;
    logic [WIDTH-1:0]   alu_y;
    logic [SHAMT_W-1:0] shamt;
    logic               mul_load;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    assign shamt    = b[SHAMT_W-1:0];
    assign busy     = state == MUL;
    assign mul_load = state == IDLE && start && operation == OP_MUL;
    seq_multiplier24 #(.W(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .step    (busy),
        .done    (mul_done),
        .product (product)
    );
    // single-cycle result; unknown codes yield zero
    always_comb begin
        alu_y = operation == OP_AND ? a & b :
                operation == OP_OR  ? a | b :
                operation == OP_ADD ? a + b :
                operation == OP_SUB ? a - b :
                operation == OP_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
                operation == OP_XOR ? a ^ b :
                operation == OP_SLL ? (int'(shamt) >= WIDTH ? '0 : a << shamt) :
                '0;
    end
    // handshake FSM and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (operation == OP_MUL) begin
                        state <= MUL;
                    end else begin
                        result   <= alu_y;
                        zero     <= alu_y == '0;
                        overflow <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                MUL: if (mul_done) begin
                    result   <= product[WIDTH-1:0];
                    zero     <= product[WIDTH-1:0] == '0;
                    overflow <= |product[2*WIDTH-1:WIDTH];
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table plus MUL, back-to-back and reset sequences
module tb_alu_exec_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  operation = 4'h0;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic [23:0] result;
    logic        zero, overflow, busy, done;
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] res;
        logic        z;
    } vec_t;
    vec_t vecs [12];

    alu_exec_unit dut (
        .clock(clock), .reset(reset), .start(start), .operation(operation),
        .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // drive a MUL, count edges to done; optionally poke an ADD at cycle 5
    task automatic run_mul(input logic [23:0] ma, input logic [23:0] mb,
                           input logic [23:0] er, input logic ez, input logic eo,
                           input bit poke);
        logic [23:0] held;
        int n;
        held = result;
        operation = 4'b0100; a = ma; b = mb; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("mul_busy_after_accept", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            if (poke && n == 5) begin
                operation = 4'b0010; a = 24'h000111; b = 24'h000222; start = 1'b1;
            end else begin
                start = 1'b0;
                a = 24'h5A5A5A; b = 24'hA5A5A5;
            end
            @(posedge clock); #1;
            n++;
            if (!done) begin
                chk("mul_result_held", result, held);
                chk("mul_no_early_done", {busy, done}, 2'b10);
            end
        end
        start = 1'b0;
        chk("mul_latency", n, 24);
        chk("mul_result", result, er);
        chk("mul_zero", zero, ez);
        chk("mul_overflow", overflow, eo);
        chk("mul_busy_cleared", busy, 0);
        @(posedge clock); #1;
        chk("mul_done_one_cycle", done, 0);
        chk("mul_result_stable", result, er);
    endtask

    initial begin
        vecs[0]  = '{4'b0010, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1};
        vecs[1]  = '{4'b1010, 24'h000005, 24'h000007, 24'hFFFFFE, 1'b0};
        vecs[2]  = '{4'b0011, 24'h800000, 24'h000001, 24'h000001, 1'b0};
        vecs[3]  = '{4'b0011, 24'h000001, 24'h800000, 24'h000000, 1'b1};
        vecs[4]  = '{4'b0110, 24'h000001, 24'h000017, 24'h800000, 1'b0};
        vecs[5]  = '{4'b0110, 24'h000001, 24'h000018, 24'h000000, 1'b1};
        vecs[6]  = '{4'b0110, 24'h000003, 24'h000021, 24'h000006, 1'b0};
        vecs[7]  = '{4'b0101, 24'hF0F0F0, 24'hFF00FF, 24'h0FF00F, 1'b0};
        vecs[8]  = '{4'b1111, 24'h000123, 24'h000456, 24'h000000, 1'b1};
        vecs[9]  = '{4'b0000, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 1'b0};
        vecs[10] = '{4'b0001, 24'h000000, 24'h000000, 24'h000000, 1'b1};
        vecs[11] = '{4'b0111, 24'h00000F, 24'h0000F0, 24'h000000, 1'b1};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_result", result, 0);
        chk("reset_zero", zero, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("idle_done", done, 0);

        for (int i = 0; i < 12; i++) begin
            operation = vecs[i].op; a = vecs[i].a; b = vecs[i].b; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
            chk($sformatf("v%0d_overflow", i), overflow, 0);
            @(posedge clock); #1;
            chk($sformatf("v%0d_done_drop", i), done, 0);
        end

        run_mul(24'h001000, 24'h001000, 24'h000000, 1'b1, 1'b1, 1'b0);
        run_mul(24'd1234, 24'd5678, 24'h6AE9BC, 1'b0, 1'b0, 1'b1);
        run_mul(24'h000000, 24'h123456, 24'h000000, 1'b1, 1'b0, 1'b0);

        operation = 4'b0000; a = 24'hF0F0F0; b = 24'hFF00FF; start = 1'b1;
        @(posedge clock); #1;
        chk("b2b_and_result", result, 24'hF000F0);
        chk("b2b_and_done", done, 1);
        operation = 4'b0001;
        @(posedge clock); #1;
        start = 1'b0;
        chk("b2b_or_result", result, 24'hFFF0FF);
        chk("b2b_or_done", done, 1);
        @(posedge clock); #1;
        chk("b2b_done_drop", done, 0);

        operation = 4'b0100; a = 24'h000003; b = 24'h000005; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        chk("midmul_busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        chk("midmul_reset_busy", busy, 0);
        chk("midmul_reset_result", result, 0);
        chk("midmul_reset_zero", zero, 1);
        chk("midmul_reset_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (30) begin
                @(posedge clock); #1;
                if (done || busy) seen++;
            end
            chk("midmul_no_late_done", seen, 0);
        end
        chk("midmul_result_after", result, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
